// File: rtl/conv_window_engine_pkg.sv
// rtl/conv_window_engine_pkg.sv - shared state type and width/bounds helpers for conv_window_engine
package conv_window_engine_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  function automatic int pad_of(input int k);
    return k / 2;
  endfunction

  function automatic int ntap_of(input int k);
    return k * k;
  endfunction

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Coordinates arrive as signed ints so a negative row/col never wraps into range.
  function automatic logic coord_ok(input int v, input int lim);
    return (v >= 0) && (v < lim);
  endfunction

endpackage

// File: rtl/conv_window_engine_if.sv
// rtl/conv_window_engine_if.sv - result stream bundle (valid/ready, pixel, coordinates, last)
interface conv_window_engine_if #(
  parameter int OUTW = 8,
  parameter int RW   = 4,
  parameter int CW   = 4
) ();

  logic            out_valid;
  logic            out_ready;
  logic [OUTW-1:0] out_data;
  logic [RW-1:0]   out_row;
  logic [CW-1:0]   out_col;
  logic            out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_row,
    output out_col,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row,
    input  out_col,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/conv_window_engine_sat_shift.sv
// rtl/conv_window_engine_sat_shift.sv - arithmetic right shift then clamp; CONV_RELU_EN selects [0, 2^OUTW-1]
module conv_window_engine_sat_shift #(
  parameter int ACCW  = 24,
  parameter int OUTW  = 8,
  parameter int SHIFT = 0
) (
  input  logic signed [ACCW-1:0] i_sum,
  output logic        [OUTW-1:0] o_data
);

`ifdef CONV_RELU_EN
  localparam logic signed [ACCW-1:0] HI = {{(ACCW-OUTW){1'b0}}, {OUTW{1'b1}}};
  localparam logic signed [ACCW-1:0] LO = '0;
`else
  localparam logic signed [ACCW-1:0] HI = {{(ACCW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] LO = ~HI;
`endif

  logic signed [ACCW-1:0] w_shifted;

  always_comb begin
    w_shifted = i_sum >>> SHIFT;
    if (w_shifted > HI) begin
      o_data = HI[OUTW-1:0];
    end else if (w_shifted < LO) begin
      o_data = LO[OUTW-1:0];
    end else begin
      o_data = w_shifted[OUTW-1:0];
    end
  end

endmodule

// File: rtl/conv_window_engine.sv
// rtl/conv_window_engine.sv - serial-MAC zero-padded KxK convolution streaming one pixel per window; CONV_RELU_EN sets clamp mode
module conv_window_engine
  import conv_window_engine_pkg::*;
#(
  parameter int IMG_H = 14,
  parameter int IMG_W = 14,
  parameter int K     = 5,
  parameter int DW    = 8,
  parameter int ACCW  = 24,
  parameter int OUTW  = 8,
  parameter int SHIFT = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic [IMG_H*IMG_W*DW-1:0] i_img,
  input  logic [K*K*DW-1:0]         i_kern,
  output logic                      o_busy,
  output logic                      o_done,
  conv_window_engine_if.master      o_out
);

  localparam int PAD  = pad_of(K);
  localparam int NTAP = ntap_of(K);
  localparam int RW   = cw(IMG_H);
  localparam int CW   = cw(IMG_W);
  localparam int TW   = cw(NTAP);
  localparam int KW   = cw(K);

  generate
    if (K < 3 || (K % 2) == 0) begin : g_bad_k
      $error("conv_window_engine: K must be odd and >= 3");
    end
    if (ACCW < 2*DW + $clog2(K*K) + 1 || ACCW <= OUTW) begin : g_bad_accw
      $error("conv_window_engine: ACCW too small");
    end
  endgenerate

  state_t r_state, w_state_nxt;

  logic [DW-1:0]          r_img  [IMG_H][IMG_W];
  logic [DW-1:0]          r_kern [K][K];
  logic signed [ACCW-1:0] r_acc;
  logic [TW-1:0]          r_tap;
  logic [KW-1:0]          r_ti, r_tj;
  logic [RW-1:0]          r_row, r_orow;
  logic [CW-1:0]          r_col, r_ocol;
  logic                   r_valid, r_last, r_done;
  logic [OUTW-1:0]        r_data;

  int                     w_sr, w_sc;
  logic                   w_inb, w_last_tap, w_fire;
  logic [DW-1:0]          w_pix, w_wt;
  logic signed [2*DW:0]   w_a, w_b, w_prod;
  logic signed [ACCW-1:0] w_sum;
  logic [OUTW-1:0]        w_sat;

  // Tap source pixel; padding positions contribute a zero product.
  always_comb begin
    w_sr  = int'(r_row) + int'(r_ti) - PAD;
    w_sc  = int'(r_col) + int'(r_tj) - PAD;
    w_inb = coord_ok(w_sr, IMG_H) && coord_ok(w_sc, IMG_W);
    w_pix = '0;
    if (w_inb) begin
      w_pix = r_img[RW'(w_sr)][CW'(w_sc)];
    end
    w_wt   = r_kern[r_ti][r_tj];
    w_a    = {{(DW+1){1'b0}}, w_pix};
    w_b    = {{(DW+1){w_wt[DW-1]}}, w_wt};
    w_prod = w_a * w_b;
    w_sum  = r_acc + {{(ACCW-2*DW-1){w_prod[2*DW]}}, w_prod};
  end

  assign w_last_tap = (r_tap == TW'(NTAP-1));
  assign w_fire     = r_valid && o_out.out_ready;

  conv_window_engine_sat_shift #(
    .ACCW  (ACCW),
    .OUTW  (OUTW),
    .SHIFT (SHIFT)
  ) u_sat_shift (
    .i_sum  (w_sum),
    .o_data (w_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start)    w_state_nxt = S_MAC;
      S_MAC:   if (w_last_tap) w_state_nxt = S_OUT;
      S_OUT:   if (w_fire)     w_state_nxt = r_last ? S_IDLE : S_MAC;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture: contents are don't-care outside a frame, so no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && i_start) begin
      for (int r = 0; r < IMG_H; r++) begin
        for (int c = 0; c < IMG_W; c++) begin
          r_img[r][c] <= i_img[(r*IMG_W+c)*DW +: DW];
        end
      end
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          r_kern[i][j] <= i_kern[(i*K+j)*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_tap   <= '0;
      r_ti    <= '0;
      r_tj    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_orow  <= '0;
      r_ocol  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_row <= '0;
            r_col <= '0;
            r_tap <= '0;
            r_ti  <= '0;
            r_tj  <= '0;
            r_acc <= '0;
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          if (w_last_tap) begin
            r_data  <= w_sat;
            r_orow  <= r_row;
            r_ocol  <= r_col;
            r_last  <= (r_row == RW'(IMG_H-1)) && (r_col == CW'(IMG_W-1));
            r_valid <= 1'b1;
          end else begin
            r_tap <= r_tap + TW'(1);
            if (r_tj == KW'(K-1)) begin
              r_tj <= '0;
              r_ti <= r_ti + KW'(1);
            end else begin
              r_tj <= r_tj + KW'(1);
            end
          end
        end
        S_OUT: begin
          if (w_fire) begin
            r_valid <= 1'b0;
            if (r_last) begin
              r_done <= 1'b1;
            end else begin
              r_acc <= '0;
              r_tap <= '0;
              r_ti  <= '0;
              r_tj  <= '0;
              if (r_col == CW'(IMG_W-1)) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
              end else begin
                r_col <= r_col + CW'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy          = (r_state != S_IDLE);
  assign o_done          = r_done;
  assign o_out.out_valid = r_valid;
  assign o_out.out_data  = r_data;
  assign o_out.out_row   = r_orow;
  assign o_out.out_col   = r_ocol;
  assign o_out.out_last  = r_last;

endmodule

// File: tb/tb_conv_window_engine.sv
// tb/tb_conv_window_engine.sv - scoreboard bench for conv_window_engine; honours CONV_RELU_EN
module tb_conv_window_engine;

  localparam int H = 14, W = 14, K = 5, DW = 8, ACCW = 24, OUTW = 8, SHIFT = 0;
  localparam int RW = 4, CW = 4;

  typedef struct {
    logic [OUTW-1:0] data;
    int              r;
    int              c;
    logic            last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [H*W*DW-1:0] img_v = '0;
  logic [K*K*DW-1:0] kern_v = '0;
  logic busy, done;

  conv_window_engine_if #(.OUTW(OUTW), .RW(RW), .CW(CW)) ifc ();

  conv_window_engine #(
    .IMG_H(H), .IMG_W(W), .K(K), .DW(DW), .ACCW(ACCW), .OUTW(OUTW), .SHIFT(SHIFT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (start),
    .i_img   (img_v),
    .i_kern  (kern_v),
    .o_busy  (busy),
    .o_done  (done),
    .o_out   (ifc.master)
  );

  always #5 clk = ~clk;

  exp_t            sbq[$];
  int              cur_img [H][W];
  int              cur_kern[K][K];
  int              nxt_img [H][W];
  int              nxt_kern[K][K];
  logic [OUTW-1:0] got     [H][W];
  int              n_tests = 0;
  int              n_fail  = 0;

`ifdef CONV_RELU_EN
  localparam int LO = 0, HI = 255;
`else
  localparam int LO = -128, HI = 127;
`endif

  function automatic int ref_pix(input int r, input int c);
    int sum = 0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        int sr = r + i - K/2;
        int sc = c + j - K/2;
        if (sr >= 0 && sr < H && sc >= 0 && sc < W) sum += cur_img[sr][sc] * cur_kern[i][j];
      end
    end
    sum = sum >>> SHIFT;
    if (sum > HI) sum = HI;
    if (sum < LO) sum = LO;
    return sum;
  endfunction

  task automatic pack_cur();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img_v[(r*W+c)*DW +: DW] = 8'(cur_img[r][c]);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) kern_v[(i*K+j)*DW +: DW] = 8'(cur_kern[i][j]);
  endtask

  task automatic fill_img(input int mode, input int lim);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        cur_img[r][c] = (mode == 0) ? ((r*14+c) % 256) : (mode == 1) ? lim : int'($urandom_range(0, lim));
  endtask

  task automatic fill_kern(input int mode, input int v);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        cur_kern[i][j] = (mode == 0) ? ((i == K/2 && j == K/2) ? 1 : 0)
                       : (mode == 1) ? v : int'($urandom_range(0, 6)) - 3;
  endtask

  // Runs one frame from a negedge; cycles counts edges from the start-sampling edge to the edge raising done.
  task automatic run_frame(input bit rand_ready, input int stall_r, input int stall_c,
                           input int abort_after, input bit inject, input bit chain,
                           input bit prestarted, output int cycles, output int done_cnt);
    int cyc = 0, nout = 0, stall_left = 10, abort_wait = 0, seen;
    exp_t e;
    sbq.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        e.data = OUTW'(ref_pix(r, c));
        e.r = r; e.c = c;
        e.last = (r == H-1) && (c == W-1);
        sbq.push_back(e);
      end
    if (!prestarted) begin
      pack_cur();
      start = 1'b1;
    end
    cycles = -1;
    done_cnt = 0;
    while (cyc < 30000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        done_cnt++;
        if (cycles < 0) cycles = cyc - 1;
        n_tests++;
        if (sbq.size() != 0) begin
          n_fail++;
          $display("FAIL done_early: done high with %0d pixels outstanding, required 0", sbq.size());
        end
        if (chain) begin
          for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) cur_img[r][c] = nxt_img[r][c];
          for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) cur_kern[i][j] = nxt_kern[i][j];
          pack_cur();
          start = 1'b1;
          return;
        end
      end
      if (inject && cyc == 100) begin
        img_v = ~img_v;
        start = 1'b1;
      end
      if (abort_after >= 0 && nout == abort_after) abort_wait++;
      if (abort_wait == 5) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || ifc.out_valid !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_state: busy=%b valid=%b done=%b, required 0 0 0", busy, ifc.out_valid, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
          @(negedge clk);
          if (done || busy || ifc.out_valid) seen++;
        end
        n_tests++;
        if (seen != 0) begin
          n_fail++;
          $display("FAIL abort_quiet: %0d cycles with done/busy/valid after abort, required 0", seen);
        end
        sbq.delete();
        return;
      end
      if (ifc.out_valid) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL extra_output: pixel (%0d,%0d) with empty scoreboard, required none",
                   ifc.out_row, ifc.out_col);
          ifc.out_ready = 1'b1;
        end else begin
          e = sbq[0];
          if (ifc.out_data !== e.data || ifc.out_row !== RW'(e.r) || ifc.out_col !== CW'(e.c) ||
              ifc.out_last !== e.last) begin
            n_fail++;
            $display("FAIL pixel: got data=%0h row=%0d col=%0d last=%b, required data=%0h row=%0d col=%0d last=%b",
                     ifc.out_data, ifc.out_row, ifc.out_col, ifc.out_last, e.data, e.r, e.c, e.last);
          end
          if (e.r == stall_r && e.c == stall_c && stall_left > 0) begin
            ifc.out_ready = 1'b0;
            stall_left--;
          end else begin
            ifc.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          end
          if (ifc.out_ready) begin
            got[e.r][e.c] = ifc.out_data;
            void'(sbq.pop_front());
            nout++;
          end
        end
      end else begin
        ifc.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (cycles >= 0 && cyc >= cycles + 3) break;
    end
    n_tests++;
    if (cycles < 0 || sbq.size() != 0) begin
      n_fail++;
      $display("FAIL frame_end: done_seen=%0d outstanding=%0d, required done and 0 outstanding",
               cycles >= 0, sbq.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL rst_busy: %b, required 0", busy); end
    n_tests++; if (done !== 1'b0)          begin n_fail++; $display("FAIL rst_done: %b, required 0", done); end
    n_tests++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: %b, required 0", ifc.out_valid); end
    n_tests++; if (ifc.out_last !== 1'b0)  begin n_fail++; $display("FAIL rst_last: %b, required 0", ifc.out_last); end
    n_tests++; if (ifc.out_data !== '0)    begin n_fail++; $display("FAIL rst_data: %0h, required 0", ifc.out_data); end
    n_tests++; if (ifc.out_row !== '0 || ifc.out_col !== '0) begin
      n_fail++; $display("FAIL rst_coord: %0d,%0d, required 0,0", ifc.out_row, ifc.out_col);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    int cyc, dc;
    fill_img(0, 0);
    fill_kern(0, 0);
    run_frame(1'b0, -1, -1, -1, 1'b0, 1'b0, 1'b0, cyc, dc);
    n_tests++; if (cyc != 5096) begin n_fail++; $display("FAIL frame_cycles: %0d, required 5096", cyc); end
    n_tests++; if (dc != 1)     begin n_fail++; $display("FAIL done_pulses: %0d, required 1", dc); end
  endtask

  task automatic test_ones();
    int cyc, dc;
    fill_img(1, 1);
    fill_kern(1, 1);
    run_frame(1'b0, -1, -1, -1, 1'b0, 1'b0, 1'b0, cyc, dc);
    n_tests++; if (got[0][0] !== 8'd9)   begin n_fail++; $display("FAIL ones_00: %0d, required 9", got[0][0]); end
    n_tests++; if (got[0][7] !== 8'd15)  begin n_fail++; $display("FAIL ones_07: %0d, required 15", got[0][7]); end
    n_tests++; if (got[7][7] !== 8'd25)  begin n_fail++; $display("FAIL ones_77: %0d, required 25", got[7][7]); end
    n_tests++; if (got[13][13] !== 8'd9) begin n_fail++; $display("FAIL ones_1313: %0d, required 9", got[13][13]); end
  endtask

  task automatic test_saturation();
    int cyc, dc;
    logic [7:0] neg_exp, pos_exp;
`ifdef CONV_RELU_EN
    neg_exp = 8'd0;   pos_exp = 8'd255;
`else
    neg_exp = 8'h80;  pos_exp = 8'd127;
`endif
    fill_img(1, 255);
    fill_kern(1, -128);
    run_frame(1'b0, -1, -1, -1, 1'b0, 1'b0, 1'b0, cyc, dc);
    n_tests++; if (got[7][7] !== neg_exp) begin n_fail++; $display("FAIL sat_neg_mid: %0h, required %0h", got[7][7], neg_exp); end
    n_tests++; if (got[0][0] !== neg_exp) begin n_fail++; $display("FAIL sat_neg_corner: %0h, required %0h", got[0][0], neg_exp); end
    fill_kern(1, 127);
    run_frame(1'b0, -1, -1, -1, 1'b0, 1'b0, 1'b0, cyc, dc);
    n_tests++; if (got[7][7] !== pos_exp) begin n_fail++; $display("FAIL sat_pos_mid: %0h, required %0h", got[7][7], pos_exp); end
    n_tests++; if (got[13][0] !== pos_exp) begin n_fail++; $display("FAIL sat_pos_corner: %0h, required %0h", got[13][0], pos_exp); end
  endtask

  task automatic test_stall_random();
    int cyc, dc;
    fill_img(2, 15);
    fill_kern(2, 0);
    run_frame(1'b1, 3, 4, -1, 1'b0, 1'b0, 1'b0, cyc, dc);
    n_tests++; if (dc != 1) begin n_fail++; $display("FAIL stall_done: %0d pulses, required 1", dc); end
  endtask

  task automatic test_abort();
    int cyc, dc;
    fill_img(2, 40);
    fill_kern(2, 0);
    run_frame(1'b0, -1, -1, 72, 1'b0, 1'b0, 1'b0, cyc, dc);
    fill_img(2, 30);
    fill_kern(2, 0);
    run_frame(1'b0, -1, -1, -1, 1'b0, 1'b0, 1'b0, cyc, dc);
    n_tests++; if (dc != 1) begin n_fail++; $display("FAIL post_abort_done: %0d pulses, required 1", dc); end
  endtask

  task automatic test_back_to_back();
    int cyc, dc;
    fill_img(2, 20);
    fill_kern(2, 0);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) nxt_img[r][c] = int'($urandom_range(0, 25));
    for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) nxt_kern[i][j] = int'($urandom_range(0, 4)) - 2;
    run_frame(1'b0, -1, -1, -1, 1'b1, 1'b1, 1'b0, cyc, dc);
    n_tests++; if (cyc != 5096) begin n_fail++; $display("FAIL b2b_first_cycles: %0d, required 5096", cyc); end
    run_frame(1'b0, -1, -1, -1, 1'b0, 1'b0, 1'b1, cyc, dc);
    n_tests++; if (cyc != 5096) begin n_fail++; $display("FAIL b2b_second_cycles: %0d, required 5096", cyc); end
    n_tests++; if (dc != 1)     begin n_fail++; $display("FAIL b2b_done: %0d pulses, required 1", dc); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_ones();
    test_saturation();
    test_stall_random();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_engine.md
Name: conv_window_engine

Overview:
Sequential 2-D same-size convolution engine: H x W unsigned image, odd K x K signed kernel, zero padding of K/2, one output pixel per window.
- Serial MAC: one kernel tap per clock.
- Output: shift, saturate, then stream in raster order over a valid/ready handshake.
- Parametrised successor of the combinational 14x14/5x5 window convolver in the MNIST feature-extraction path.

Parameters:
IMG_H, 14, image rows
IMG_W, 14, image columns
K, 5, kernel side; odd, >=3; PAD = K/2
DW, 8, pixel and weight width
ACCW, 24, signed accumulator width; >= 2*DW+clog2(K*K)+1
OUTW, 8, output pixel width
SHIFT, 0, arithmetic right shift applied to final sum before clamping

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin a frame; sampled only in IDLE
img_i  in  IMG_H*IMG_W*DW  pixels, unsigned; pixel (r,c) at bits [(r*IMG_W+c)*DW +: DW]
kern_i  in  K*K*DW  weights, two's complement; tap (i,j) at bits [(i*K+j)*DW +: DW]
busy  out  1  high from accepted start until the frame completes
out_valid  out  1  out_data holds a result
out_ready  in  1  consumer accepts
out_data  out  OUTW  result pixel
out_row  out  clog2(IMG_H)  row of out_data
out_col  out  clog2(IMG_W)  column of out_data
out_last  out  1  high with the final pixel (IMG_H-1, IMG_W-1)
done  out  1  one-cycle pulse after the last handshake

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; busy, out_valid, out_last, done = 0; out_data, out_row, out_col, acc, tap, row, col = 0.
- Reset mid-frame: aborts immediately. No done pulse. Latched data is discarded.
- States:
  - IDLE: on start=1, latch img_i and kern_i into internal registers; row=col=0, tap=0, acc=0; go MAC; busy=1.
  - MAC: each cycle adds the product for tap t = (i,j), i=t/K, j=t%K, to acc.
    - Source pixel is (row+i-PAD, col+j-PAD).
    - Out-of-bounds coordinate: product is 0. Bounds are checked with signed or extended arithmetic; never unsigned wrap.
    - Product = zero-extended pixel times sign-extended weight, sign-extended to ACCW.
    - At t = K*K-1: out_data <= clamp((acc + product) >>> SHIFT); out_row, out_col <= row, col; out_last <= (row==IMG_H-1 && col==IMG_W-1); out_valid <= 1; go OUT.
  - OUT: hold out_data, out_row, out_col, out_last stable while out_valid=1 and out_ready=0.
    - On out_valid && out_ready: out_valid <= 0.
    - If out_last: go IDLE, busy <= 0, done <= 1 for one cycle.
    - Otherwise: advance col (wrap to 0 and increment row at IMG_W-1), acc=0, tap=0, go MAC.
- Latency: out_valid rises K*K cycles after the edge that samples start. With out_ready tied high, a pixel completes every K*K+1 cycles, giving a frame of IMG_H*IMG_W*(K*K+1) cycles (5096 at defaults).
- start while busy: ignored. start in the same cycle as done: accepted, because the state is already IDLE.
- img_i and kern_i are don't-care after the start cycle.
- Accumulator must not overflow given the ACCW rule. Elaboration fails if K is even or ACCW is too small.

Optional Feature:
CONV_RELU_EN
- Defined: clamp range [0, 2^OUTW-1]; negative sums give 0; out_data is unsigned.
- Undefined: clamp range [-2^(OUTW-1), 2^(OUTW-1)-1]; out_data is two's complement.

Decomposition:
- conv_pkg: state enum (IDLE, MAC, OUT); localparams PAD, NTAP=K*K, coordinate widths; signed bounds-check helper function.
- Sub-module conv_sat_shift: combinational arithmetic shift plus clamp, honouring CONV_RELU_EN. Instantiated once, on the MAC-to-OUT path.

Test Plan:
1. Image pixel = (r*14+c)%256, kernel center tap 1, others 0, SHIFT=0, out_ready=1 -> out_data equals source pixel (in range) for all 196 outputs in raster order; out_last only on (13,13); done pulses once; total 5096 cycles.
2. All-ones image, all-ones kernel -> (0,0)=9, (0,7)=15, (7,7)=25, (13,13)=9; padding taps contribute zero.
3. All-255 image, all weights -128, RELU off -> every output -128 (saturated). With CONV_RELU_EN -> every output 0. All weights +127 -> 127 (RELU off) / 255 (RELU on).
4. out_ready toggled randomly, held low 10 cycles on pixel (3,4) -> out_data, out_row, out_col stable while stalled; no pixel lost or duplicated; ordering preserved.
5. rst_n=0 for one cycle during MAC of pixel (5,2) -> next cycle busy=0, out_valid=0, no done; a new start produces a full correct frame.
6. start pulsed while busy with a different image -> ignored, first frame unchanged; start asserted on the done cycle -> second frame starts immediately and matches its reference.
